// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared defaults, bank index type and bit-reversal helper for the FFT reorder buffer
package fft_reorder_pkg;
   localparam int LOG2N_DEF = 5;
   localparam int DW_DEF    = 17;
   typedef logic bank_t;
   function automatic logic [9:0] bitrev(input logic [9:0] idx, input int log2n);
      logic [9:0] r;
      r = {<<{idx}};
      return r >> (10 - log2n);
   endfunction
endpackage

// File: rtl/reorder_bank_ram.sv
// reorder_bank_ram: one frame of sample storage, synchronous write, combinational read
module reorder_bank_ram #(
   parameter int AW = 5,
   parameter int W  = 34
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [2**AW];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT output into natural order, with per-frame bypass
module fft_bitrev_reorder
   import fft_reorder_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_r,
   input  logic [DW-1:0] in_i,
   input  logic          in_bypass,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_r,
   output logic [DW-1:0] out_i,
   output logic          out_first,
   output logic          out_last
);
   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_addr;
   bank_t            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]       full_cnt_q, full_cnt_d, byp_q, byp_d;
   logic             out_valid_q, out_valid_d, out_first_q, out_first_d, out_last_q, out_last_d;
   logic [DW-1:0]    out_r_q, out_r_d, out_i_q, out_i_d;
   logic             in_fire, wr_byp, wr_done, load, rd_done;
   logic [2*DW-1:0]  rdata0, rdata1, rdata;

   // the bypass flag for a frame comes straight from the port on its first sample
   always_comb begin
      in_ready    = full_cnt_q != 2'd2;
      in_fire     = in_valid && in_ready;
      wr_byp      = (wr_cnt_q == '0) ? in_bypass : byp_q[wr_ptr_q];
      wr_addr     = wr_byp ? wr_cnt_q : LOG2N'(bitrev(10'(wr_cnt_q), LOG2N));
      wr_done     = in_fire && (&wr_cnt_q);
      load        = (full_cnt_q != 2'd0) && (!out_valid_q || out_ready);
      rd_done     = load && (&rd_cnt_q);
      rdata       = rd_ptr_q ? rdata1 : rdata0;
      wr_cnt_d    = in_fire ? wr_cnt_q + 1'b1 : wr_cnt_q;
      wr_ptr_d    = wr_ptr_q ^ wr_done;
      rd_cnt_d    = load ? rd_cnt_q + 1'b1 : rd_cnt_q;
      rd_ptr_d    = rd_ptr_q ^ rd_done;
      full_cnt_d  = full_cnt_q + 2'(wr_done) - 2'(rd_done);
      byp_d       = byp_q;
      if (in_fire && wr_cnt_q == '0) byp_d[wr_ptr_q] = in_bypass;
      out_valid_d = load || (out_valid_q && !out_ready);
      out_r_d     = load ? rdata[2*DW-1:DW] : out_r_q;
      out_i_d     = load ? rdata[DW-1:0] : out_i_q;
      out_first_d = load ? (rd_cnt_q == '0) : out_first_q;
      out_last_d  = load ? (&rd_cnt_q) : out_last_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         full_cnt_q  <= '0;
         byp_q       <= '0;
         out_valid_q <= 1'b0;
         out_r_q     <= '0;
         out_i_q     <= '0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         full_cnt_q  <= full_cnt_d;
         byp_q       <= byp_d;
         out_valid_q <= out_valid_d;
         out_r_q     <= out_r_d;
         out_i_q     <= out_i_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
      end
   end

   reorder_bank_ram #(.AW(LOG2N), .W(2*DW)) u_ping (
      .clk(clk), .we(in_fire && !wr_ptr_q), .waddr(wr_addr), .wdata({in_r, in_i}),
      .raddr(rd_cnt_q), .rdata(rdata0)
   );
   reorder_bank_ram #(.AW(LOG2N), .W(2*DW)) u_pong (
      .clk(clk), .we(in_fire && wr_ptr_q), .waddr(wr_addr), .wdata({in_r, in_i}),
      .raddr(rd_cnt_q), .rdata(rdata1)
   );

   assign out_valid = out_valid_q;
   assign out_r     = out_r_q;
   assign out_i     = out_i_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: table-driven and randomized scoreboard bench for the bit-reversal reorder buffer
module tb_fft_bitrev_reorder;
   localparam int LOG2N = 5;
   localparam int N     = 32;
   localparam int DW    = 17;

   logic clk = 0, rst_n = 0, in_valid = 0, in_bypass = 0, out_ready = 0;
   logic signed [DW-1:0] in_r = 0, in_i = 0;
   logic in_ready, out_valid, out_first, out_last;
   logic signed [DW-1:0] out_r, out_i;

   fft_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_i(in_i), .in_bypass(in_bypass), .out_valid(out_valid),
      .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
      .out_first(out_first), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {logic signed [DW-1:0] r, i, er, ei;} vec_t;
   typedef struct {logic signed [DW-1:0] r, i; logic f, l;} exp_t;
   exp_t exp_q[$];
   vec_t tbl[N];
   logic signed [DW-1:0] fr_r[N], fr_i[N];
   int n_checks = 0, n_fail = 0, cyc = 0, n_acc = 0, stalls = 0;
   int n_out = 0, first_cyc = -1, last_cyc = -1;
   bit rnd_ready = 0, done3 = 0;

   function automatic int rev(int x);
      int v = 0;
      for (int b = 0; b < LOG2N; b++) v = v * 2 + (x >> b) % 2;
      return v;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom);
   end

   logic pv = 0, pr = 0, prst = 0;
   logic [35:0] pd = 0;
   always @(negedge clk) begin
      if (rst_n && prst && pv && !pr)
         check("hold", {out_valid, out_r, out_i, out_first, out_last}, {1'b1, pd});
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got r=%0d i=%0d with no sample pending", out_r, out_i);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", {out_r, out_i, out_first, out_last}, {e.r, e.i, e.f, e.l});
         end
      end
      pv = out_valid; pr = out_ready; prst = rst_n;
      pd = {out_r, out_i, out_first, out_last};
   end

   task automatic send(input logic signed [DW-1:0] r, input logic signed [DW-1:0] i, input logic byp);
      int w = 0;
      logic ok;
      in_valid = 1; in_r = r; in_i = i; in_bypass = byp;
      forever begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
         w++;
         if (w > 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", w);
            break;
         end
      end
      if (ok) n_acc++;
      if (w > 0) stalls++;
   endtask

   task automatic push_model(input logic byp);
      for (int j = 0; j < N; j++) begin
         int idx;
         idx = byp ? j : rev(j);
         exp_q.push_back('{fr_r[idx], fr_i[idx], j == 0, j == N - 1});
      end
   endtask

   task automatic send_frame(input logic byp);
      for (int k = 0; k < N; k++) send(fr_r[k], fr_i[k], k == 0 ? byp : 1'($urandom));
      in_valid = 0;
      push_model(byp);
   endtask

   task automatic fill_rand;
      for (int k = 0; k < N; k++) begin
         fr_r[k] = DW'($urandom);
         fr_i[k] = DW'($urandom);
      end
   endtask

   task automatic drain;
      int w = 0;
      while (exp_q.size() > 0 && w < 2000) begin
         @(posedge clk);
         w++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic win_reset;
      n_out = 0; first_cyc = -1; last_cyc = -1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic signed [DW-1:0] ext_r[4], ext_i[4];
      int w;
      for (int k = 0; k < N; k++) begin
         tbl[k].r  = DW'(k);
         tbl[k].i  = DW'(-k);
         tbl[k].er = DW'(rev(k));
         tbl[k].ei = DW'(-rev(k));
      end
      ext_r = '{-17'sd65536, 17'sd65535, -17'sd65536, 17'sd65535};
      ext_i = '{-17'sd65536, 17'sd65535, 17'sd65535, -17'sd65536};

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_r", out_r, 0);
      check("rst_out_i", out_i, 0);
      check("rst_out_first", out_first, 0);
      check("rst_out_last", out_last, 0);
      rst_n = 1;
      out_ready = 1;

      // 1: ramp frame, expected order taken from the table
      for (int k = 0; k < N; k++) send(tbl[k].r, tbl[k].i, k == 0 ? 1'b0 : 1'($urandom));
      in_valid = 0;
      for (int j = 0; j < N; j++) exp_q.push_back('{tbl[j].er, tbl[j].ei, j == 0, j == N - 1});
      @(negedge clk);
      check("lat_bubble", out_valid, 0);
      @(negedge clk);
      check("lat_first_valid", out_valid, 1);
      check("lat_first_flag", out_first, 1);
      drain;

      // 2: four back-to-back frames
      @(posedge clk); #1;
      win_reset;
      stalls = 0;
      repeat (4) begin
         fill_rand;
         send_frame(0);
      end
      drain;
      check("stream_stalls", stalls, 0);
      check("stream_count", n_out, 4 * N);
      check("stream_span", last_cyc - first_cyc + 1, 4 * N);

      // 3: backpressure with three frames offered
      @(posedge clk); #1;
      out_ready = 0;
      n_acc = 0;
      done3 = 0;
      fork
         begin
            repeat (3) begin
               fill_rand;
               send_frame(0);
            end
            done3 = 1;
         end
      join_none
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("bp_accepted", n_acc, 2 * N);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_r", out_r, exp_q[0].r);
      check("bp_out_first", out_first, 1);
      @(posedge clk); #1;
      out_ready = 1;
      w = 0;
      while (!done3 && w < 2000) begin
         @(posedge clk);
         w++;
      end
      #2;
      check("bp_third_done", done3, 1);
      drain;
      check("bp_total_acc", n_acc, 3 * N);

      // 4: bypass frame then reorder frame
      @(posedge clk); #1;
      win_reset;
      for (int k = 0; k < N; k++) begin
         fr_r[k] = DW'(k);
         fr_i[k] = DW'($urandom);
      end
      send_frame(1);
      fill_rand;
      send_frame(0);
      drain;
      check("byp_count", n_out, 2 * N);
      check("byp_span", last_cyc - first_cyc + 1, 2 * N);

      // 5: signed extremes under random backpressure
      @(posedge clk); #1;
      rnd_ready = 1;
      repeat (2) begin
         for (int k = 0; k < N; k++) begin
            fr_r[k] = ext_r[k % 4];
            fr_i[k] = ext_i[(k / 4) % 4];
         end
         send_frame(0);
      end
      drain;
      rnd_ready = 0;
      @(posedge clk); #2;
      out_ready = 1;

      // 6: reset in the middle of a frame while the previous one drains
      fill_rand;
      send_frame(0);
      fill_rand;
      for (int k = 0; k < 10; k++) send(fr_r[k], fr_i[k], 0);
      in_valid = 0;
      rst_n = 0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1;
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_in_ready", in_ready, 1);
      win_reset;
      repeat (40) @(posedge clk);
      #1;
      check("rst_mid_no_stale", n_out, 0);
      fill_rand;
      send_frame(0);
      drain;
      check("rst_mid_fresh_count", n_out, N);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
